// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared types and defaults for the control pipeline stage
// Contents:
//   ctrl_bundle_t        decoded control bundle carried per buffer entry
//   CTRL_W               width of ctrl_bundle_t
//   CTRL_PIPE_DEPTH_DEF  default entry count (2 = skid buffer)
package ctrl_pipe_pkg;

  typedef struct packed {
    logic       alu_st;
    logic       mem_st;
    logic       shift_op;
    logic [1:0] mem_op;
    logic [1:0] esc_wr;
    logic [1:0] vec_wr;
    logic [3:0] alu_op;
  } ctrl_bundle_t;

  localparam int CTRL_W              = 13;
  localparam int CTRL_PIPE_DEPTH_DEF = 2;

endpackage

// File: rtl/ctrl_pipe_stage_if.sv
// rtl/ctrl_pipe_stage_if.sv - handshake bundle between decode, the pipe stage and its consumer
// Signals:
//   flush      discard held entries and same-cycle input
//   in_valid   upstream offers in_data
//   in_data    W-bit control bundle
//   in_ready   stage can accept
//   out_valid  head entry valid
//   out_data   head entry (zero when empty)
//   out_ready  downstream consumes head
//   count      current occupancy
// Modports: master = bench/upstream side, slave = the stage itself.
interface ctrl_pipe_stage_if
  import ctrl_pipe_pkg::*;
#(
  parameter int W     = CTRL_W,
  parameter int DEPTH = CTRL_PIPE_DEPTH_DEF
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/ctrl_pipe_sat_cnt.sv
// rtl/ctrl_pipe_sat_cnt.sv - 16-bit saturating event counter
// Ports:
//   clk      clock
//   clear_i  synchronous clear (highest priority)
//   inc_i    count one event this cycle
//   cnt_o    current count, holds at all-ones
module ctrl_pipe_sat_cnt (
  input  logic        clk,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - DEPTH-entry FIFO pipe stage for decoded control bundles
// Ports:
//   clk        clock, all state on posedge
//   reset      synchronous, active-high
//   bus        ctrl_pipe_stage_if.slave (flush, in_*, out_*, count)
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
//              (only when CTRL_PIPE_PERF_EN is defined)
// Optional feature macro: CTRL_PIPE_PERF_EN
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int W     = CTRL_W,
  parameter int DEPTH = CTRL_PIPE_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  ctrl_pipe_stage_if.slave  bus
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;

  // Circular pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake outputs depend only on registered count and reset.
  assign in_ready  = !reset && (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);

  // in_ready already excludes reset; pop during reset is overridden below.
  assign push = bus.in_valid && in_ready && !bus.flush;
  assign pop  = out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset || bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Entry storage is never cleared; emptiness is handled by masking out_data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;

`ifdef CTRL_PIPE_PERF_EN
  // Counts back-pressure cycles; survives flush, cleared only by reset.
  ctrl_pipe_sat_cnt u_stall_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (out_valid && !bus.out_ready),
    .cnt_o   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// tb/tb_ctrl_pipe_stage.sv - self-checking bench for ctrl_pipe_stage
module tb_ctrl_pipe_stage;
  import ctrl_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_pipe_stage_if #(.W(CTRL_W), .DEPTH(2)) b2 ();
  ctrl_pipe_stage_if #(.W(CTRL_W), .DEPTH(4)) b4 ();

`ifdef CTRL_PIPE_PERF_EN
  logic [15:0] stall2, stall4;
`endif

  ctrl_pipe_stage #(.W(CTRL_W), .DEPTH(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .bus       (b2)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .stall_cnt (stall2)
`endif
  );

  ctrl_pipe_stage #(.W(CTRL_W), .DEPTH(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .bus       (b4)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .stall_cnt (stall4)
`endif
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [12:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [12:0] exp_data;
    int          exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[13];

  task automatic drive2(input logic fl, input logic iv, input logic [12:0] d, input logic ordy);
    b2.flush = fl; b2.in_valid = iv; b2.in_data = d; b2.out_ready = ordy;
  endtask

  task automatic check2(input string tag, input logic v, input logic [12:0] d, input int c, input logic r);
    check({tag, ".out_valid"}, b2.out_valid, v);
    check({tag, ".out_data"},  b2.out_data, d);
    check({tag, ".count"},     b2.count, c);
    check({tag, ".in_ready"},  b2.in_ready, r);
  endtask

  // Reference model for the DEPTH=4 random run: a plain queue.
  logic [12:0] model_q[$];
  int          pushes4;
  int          max_cnt4;

  initial begin
    // fl, iv, data, ordy | valid, data, count, ready  (state after the edge)
    vecs[0]  = '{0, 1, 13'h0A5, 0, 1, 13'h0A5, 1, 1};
    vecs[1]  = '{0, 0, 13'h000, 1, 0, 13'h000, 0, 1};
    vecs[2]  = '{0, 1, 13'h001, 0, 1, 13'h001, 1, 1};
    vecs[3]  = '{0, 1, 13'h002, 0, 1, 13'h001, 2, 0};
    vecs[4]  = '{0, 1, 13'h003, 0, 1, 13'h001, 2, 0};
    vecs[5]  = '{0, 0, 13'h000, 1, 1, 13'h002, 1, 1};
    vecs[6]  = '{0, 0, 13'h000, 1, 0, 13'h000, 0, 1};
    vecs[7]  = '{0, 1, 13'h004, 1, 1, 13'h004, 1, 1};
    vecs[8]  = '{0, 1, 13'h005, 1, 1, 13'h005, 1, 1};
    vecs[9]  = '{0, 1, 13'h006, 0, 1, 13'h005, 2, 0};
    vecs[10] = '{1, 1, 13'h1FF, 1, 0, 13'h000, 0, 1};
    vecs[11] = '{0, 0, 13'h000, 1, 0, 13'h000, 0, 1};
    vecs[12] = '{0, 1, 13'h007, 0, 1, 13'h007, 1, 1};

    drive2(0, 0, '0, 0);
    b4.flush = 0; b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_active.in_ready2", b2.in_ready, 1'b0);
    check("rst_active.in_ready4", b4.in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check2("post_reset2", 0, 13'h000, 0, 1);
    check("post_reset4.out_valid", b4.out_valid, 1'b0);
    check("post_reset4.count", b4.count, 0);
    check("post_reset4.in_ready", b4.in_ready, 1'b1);
`ifdef CTRL_PIPE_PERF_EN
    check("post_reset.stall_cnt", stall2, 16'h0);
`endif

    // Directed table on the DEPTH=2 skid configuration.
    for (int i = 0; i < 13; i++) begin
      drive2(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      @(negedge clk);
      check2($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
             vecs[i].exp_count, vecs[i].exp_ready);
    end

    // Reset mid-operation discards entries; input during reset is not taken.
    drive2(0, 1, 13'h008, 0);
    @(negedge clk);
    check2("fill_before_reset", 1, 13'h007, 2, 0);
    reset = 1'b1;
    drive2(0, 1, 13'h009, 1);
    @(negedge clk);
    check("mid_reset.in_ready", b2.in_ready, 1'b0);
    check("mid_reset.count", b2.count, 0);
    reset = 1'b0;
    drive2(0, 0, '0, 1);
    #1;
    check2("after_mid_reset", 0, 13'h000, 0, 1);
    @(negedge clk);
    check2("after_mid_reset_hold", 0, 13'h000, 0, 1);

    // Streaming: one bundle per cycle with steady occupancy of one.
    for (int i = 0; i < 100; i++) begin
      drive2(0, 1, 13'(i + 16), 1);
      @(negedge clk);
      check($sformatf("stream%0d.out_valid", i), b2.out_valid, 1'b1);
      check($sformatf("stream%0d.out_data", i), b2.out_data, 13'(i + 16));
      check($sformatf("stream%0d.count", i), b2.count, 1);
    end
    drive2(0, 0, '0, 1);
    @(negedge clk);
    check2("stream_drain", 0, 13'h000, 0, 1);
    drive2(0, 0, '0, 0);

    // Randomised run on DEPTH=4 against a queue model.
    pushes4  = 0;
    max_cnt4 = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic fl, iv, ordy, m_ready, m_valid, do_push, do_pop;
      logic [12:0] d;
      fl   = ($urandom_range(0, 199) == 0);
      iv   = $urandom_range(0, 1);
      ordy = $urandom_range(0, 1);
      d    = 13'($urandom);
      b4.flush = fl; b4.in_valid = iv; b4.in_data = d; b4.out_ready = ordy;
      m_ready = (model_q.size() < 4);
      m_valid = (model_q.size() != 0);
      do_push = iv && m_ready && !fl;
      do_pop  = m_valid && ordy;
      @(negedge clk);
      if (fl) begin
        model_q.delete();
      end else begin
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) begin
          model_q.push_back(d);
          pushes4++;
        end
      end
      if (model_q.size() > max_cnt4) max_cnt4 = model_q.size();
      check($sformatf("rnd%0d.count", cyc), b4.count, model_q.size());
      check($sformatf("rnd%0d.out_valid", cyc), b4.out_valid, model_q.size() != 0);
      check($sformatf("rnd%0d.in_ready", cyc), b4.in_ready, model_q.size() < 4);
      check($sformatf("rnd%0d.out_data", cyc), b4.out_data,
            (model_q.size() != 0) ? model_q[0] : 13'h000);
    end
    check("rnd.reached_full", max_cnt4, 4);
    check("rnd.wrapped", pushes4 > 8, 1'b1);
    b4.flush = 0; b4.in_valid = 0; b4.out_ready = 0;

`ifdef CTRL_PIPE_PERF_EN
    reset = 1'b1;
    drive2(0, 0, '0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("perf.cleared", stall2, 16'h0);
    drive2(0, 1, 13'h001, 0);
    @(negedge clk);
    drive2(0, 0, '0, 0);
    repeat (10) @(negedge clk);
    check("perf.ten", stall2, 16'd10);
    repeat (70000) @(negedge clk);
    check("perf.saturated", stall2, 16'hFFFF);
    drive2(1, 0, '0, 0);
    @(negedge clk);
    drive2(0, 0, '0, 0);
    check("perf.after_flush", stall2, 16'hFFFF);
    check("perf.flush_count", b2.count, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("perf.after_reset", stall2, 16'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage.md
CTRL_PIPE_STAGE -- requirements
Module: ctrl_pipe_stage

Interface
REQ-001 Parameter W, default 13: width of the control bundle carried per entry (1..64).
REQ-002 Parameter DEPTH, default 2: entry count of internal buffer (2..8); DEPTH=2 is the skid configuration.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  discard all held entries and any same-cycle input.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  W  control bundle from decode.
REQ-008 in_ready  output  1  stage can accept; asserted when count < DEPTH and reset low.
REQ-009 out_valid  output  1  head entry valid; asserted when count != 0.
REQ-010 out_data  output  W  head entry bundle; all zeros when count == 0.
REQ-011 out_ready  input  1  downstream consumes head.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 stall_cnt  output  16  saturating stall-cycle counter; present only with CTRL_PIPE_PERF_EN.

Function
REQ-014 Push = in_valid && in_ready && !flush; pop = out_valid && out_ready; both evaluated in the same cycle.
REQ-015 Latency: bundle pushed at edge n appears on out_data with out_valid from cycle n+1 when the buffer was empty.
REQ-016 Order: strict FIFO; circular read/write pointers wrap from DEPTH-1 to 0.
REQ-017 Push and pop together: count unchanged; head advances; the new entry is written at the tail.
REQ-018 Full (count == DEPTH): in_ready = 0; in_valid is ignored; pop alone decrements count.
REQ-019 Empty: out_valid = 0, out_data = 0; out_ready is ignored.
REQ-020 Sustained in_valid=1, out_ready=1: one bundle per cycle, no bubbles after the first.
REQ-021 flush: next cycle count = 0, pointers = 0, out_valid = 0; flush has priority over push and pop in the same cycle.
REQ-022 Entry storage is not required to be cleared on pop or flush; out_data masking to zero when empty is mandatory.
REQ-023 in_ready and out_valid are functions of registered count and reset only; there is no combinational path from in_valid or out_ready to them.

Reset
REQ-024 While reset is high: in_ready = 0; no push or pop.
REQ-025 First cycle after reset: count = 0, out_valid = 0, out_data = 0, in_ready = 1, pointers = 0, stall_cnt = 0.
REQ-026 Reset mid-operation discards all entries exactly like flush and additionally clears stall_cnt.

Configuration
REQ-027 Macro CTRL_PIPE_PERF_EN defined: stall_cnt port exists; increments by 1 on each cycle with out_valid && !out_ready; saturates at 16'hFFFF; cleared only by reset, not by flush.
REQ-028 Macro CTRL_PIPE_PERF_EN undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Structure
REQ-029 Package ctrl_pipe_pkg holds the ctrl_bundle_t packed struct (alu_st, mem_st, shift_op 1b each; mem_op, esc_wr, vec_wr 2b each; alu_op 4b; 13 bits total) and localparam CTRL_W = 13.
REQ-030 Package ctrl_pipe_pkg holds localparam CTRL_PIPE_DEPTH_DEF = 2.
REQ-031 The saturating counter is sub-module ctrl_pipe_sat_cnt (16-bit, inc, clear) and is instantiated only under CTRL_PIPE_PERF_EN.
REQ-032 Storage is a register array inside ctrl_pipe_stage; no memory macro is used.

Verification
REQ-033 After reset, push 13'h0A5 with out_ready=0 -> next cycle out_valid=1, out_data=13'h0A5, count=1, in_ready=1.
REQ-034 DEPTH=2, out_ready=0, push 13'h001 then 13'h002 -> count=2, in_ready=0; a third in_valid with 13'h003 is dropped; set out_ready=1 -> outputs 13'h001, then 13'h002, then out_valid=0.
REQ-035 Stream 100 incrementing bundles with in_valid=1, out_ready=1 -> 100 outputs in order, count constant at 1, no bubble after the first.
REQ-036 count=2, assert flush together with in_valid=1 (13'h1FF) and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0; 13'h1FF never appears.
REQ-037 With CTRL_PIPE_PERF_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; a flush leaves stall_cnt at 16'hFFFF; reset -> 0.
REQ-038 DEPTH=4, random in_valid/out_ready at 50% for 10000 cycles -> scoreboard order matches; count never exceeds 4; pointer wrap is exercised.
